// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and defaults for the clock-gate enable controller.
package clk_gate_ctrl_pkg;

  // Controller states. WAKE is the reset state, so the clock runs out of reset.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } gate_state_t;

  // Cycles clk_en is held high before clk_ack asserts.
  localparam int unsigned WAKE_LAT_DEF = 2;

endpackage

// File: rtl/clk_gate_idle_cnt.sv
// Saturating idle-hysteresis counter with clear/increment and a >= threshold flag.
module clk_gate_idle_cnt #(
  parameter int unsigned IDLE_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [IDLE_CNT_W-1:0] thresh,
  output logic                  reach
);

  logic [IDLE_CNT_W-1:0] cnt;

  // Idle counter: clear wins over increment; increment stops at all-ones.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + IDLE_CNT_W'(1);
    end
  end

  // Compare against the live threshold so lowering it mid-count gates promptly.
  assign reach = (cnt >= thresh);

endmodule

// File: rtl/clk_gate_en_ctrl.sv
// Gate-enable controller for a te-capable clock-gate cell. Runs on the ungated
// clock, gates after programmable idle hysteresis, and re-enables on a level
// wake request with a req/ack handshake. Counts gating events for debug.
module clk_gate_en_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CNT_W = 8,
  parameter int unsigned WAKE_LAT   = WAKE_LAT_DEF,
  parameter int unsigned EVT_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  busy,
  input  logic                  wake_req,
  output logic                  clk_ack,
  input  logic                  force_on,
  input  logic [IDLE_CNT_W-1:0] idle_thresh,
  input  logic                  scan_mode,
  output logic                  clk_en,
  output logic                  gate_te,
  output logic                  gated,
  output logic [EVT_CNT_W-1:0]  gate_evt_cnt
);

  // Wake counter only needs to reach WAKE_LAT-1; keep at least one bit.
  localparam int unsigned WAKE_CNT_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_LAT - 1);

  gate_state_t           state;
  logic [WAKE_CNT_W-1:0] wake_cnt;
  logic                  active;
  logic                  idle_inc;
  logic                  idle_clr;
  logic                  idle_reach;

  // Anything that keeps the domain clock running; a zero threshold disables gating.
  assign active = busy | wake_req | force_on | scan_mode | (idle_thresh == '0);

  // Scan enable goes straight to the gate cell so DFT control is never delayed.
  assign gate_te = scan_mode;

  // Count idle cycles from RUN (entering IDLE at 1) and in IDLE until the
  // threshold is reached; every other situation restarts the hysteresis.
  assign idle_inc = !active && ((state == ST_RUN) || ((state == ST_IDLE) && !idle_reach));
  assign idle_clr = !idle_inc;

  clk_gate_idle_cnt #(
    .IDLE_CNT_W (IDLE_CNT_W)
  ) u_idle_cnt (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr    (idle_clr),
    .inc    (idle_inc),
    .thresh (idle_thresh),
    .reach  (idle_reach)
  );

  // Gate FSM with registered enable/ack/status outputs, wake counter and event counter.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= ST_WAKE;
      wake_cnt     <= '0;
      clk_en       <= 1'b1;
      clk_ack      <= 1'b0;
      gated        <= 1'b0;
      gate_evt_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!active) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (active) begin
            state <= ST_RUN;
          end else if (idle_reach) begin
            state   <= ST_GATED;
            clk_en  <= 1'b0;
            clk_ack <= 1'b0;
            gated   <= 1'b1;
            if (gate_evt_cnt != '1) begin
              gate_evt_cnt <= gate_evt_cnt + EVT_CNT_W'(1);
            end
          end
        end
        ST_GATED: begin
          if (active) begin
            state    <= ST_WAKE;
            wake_cnt <= '0;
            clk_en   <= 1'b1;
            gated    <= 1'b0;
          end
        end
        ST_WAKE: begin
          // Activity is ignored here: a dropped request still completes to RUN.
          if (wake_cnt == WAKE_LAST) begin
            state   <= ST_RUN;
            clk_ack <= 1'b1;
          end else begin
            wake_cnt <= wake_cnt + WAKE_CNT_W'(1);
          end
        end
        default: begin
          state    <= ST_WAKE;
          wake_cnt <= '0;
          clk_en   <= 1'b1;
          clk_ack  <= 1'b0;
          gated    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_gate_en_ctrl.sv
// Directed self-checking bench for clk_gate_en_ctrl. A second instance with a
// 2-bit event counter shares all inputs so counter saturation is reached quickly.
module tb_clk_gate_en_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        busy;
  logic        wake_req;
  logic        force_on;
  logic        scan_mode;
  logic [7:0]  idle_thresh;

  logic        clk_ack,   clk_en,   gate_te,   gated;
  logic [15:0] gate_evt_cnt;
  logic        clk_ack_s, clk_en_s, gate_te_s, gated_s;
  logic [1:0]  gate_evt_cnt_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clk_gate_en_ctrl #(
    .IDLE_CNT_W (8),
    .WAKE_LAT   (2),
    .EVT_CNT_W  (16)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .busy         (busy),
    .wake_req     (wake_req),
    .clk_ack      (clk_ack),
    .force_on     (force_on),
    .idle_thresh  (idle_thresh),
    .scan_mode    (scan_mode),
    .clk_en       (clk_en),
    .gate_te      (gate_te),
    .gated        (gated),
    .gate_evt_cnt (gate_evt_cnt)
  );

  clk_gate_en_ctrl #(
    .IDLE_CNT_W (8),
    .WAKE_LAT   (2),
    .EVT_CNT_W  (2)
  ) dut_sat (
    .clk          (clk),
    .rst_b        (rst_b),
    .busy         (busy),
    .wake_req     (wake_req),
    .clk_ack      (clk_ack_s),
    .force_on     (force_on),
    .idle_thresh  (idle_thresh),
    .scan_mode    (scan_mode),
    .clk_en       (clk_en_s),
    .gate_te      (gate_te_s),
    .gated        (gated_s),
    .gate_evt_cnt (gate_evt_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check every output of both instances against the expected values.
  task automatic expect_all(input string tag, input logic en, input logic ack,
                            input logic gd, input logic [15:0] ev, input logic [1:0] ev_s);
    check({tag, ".clk_en"},     32'(clk_en),         32'(en));
    check({tag, ".clk_ack"},    32'(clk_ack),        32'(ack));
    check({tag, ".gated"},      32'(gated),          32'(gd));
    check({tag, ".evt"},        32'(gate_evt_cnt),   32'(ev));
    check({tag, ".gate_te"},    32'(gate_te),        32'(scan_mode));
    check({tag, ".s_clk_en"},   32'(clk_en_s),       32'(en));
    check({tag, ".s_clk_ack"},  32'(clk_ack_s),      32'(ack));
    check({tag, ".s_gated"},    32'(gated_s),        32'(gd));
    check({tag, ".s_evt"},      32'(gate_evt_cnt_s), 32'(ev_s));
    check({tag, ".s_gate_te"},  32'(gate_te_s),      32'(scan_mode));
  endtask

  // Absolute time limit so the run always ends even if the clock stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_b       = 1'b0;
    busy        = 1'b0;
    wake_req    = 1'b0;
    force_on    = 1'b0;
    scan_mode   = 1'b0;
    idle_thresh = 8'd4;

    // Reset values, then boot: ack after 2 edges, gate on the 7th edge.
    #12;
    expect_all("reset", 1, 0, 0, 0, 0);
    rst_b = 1'b1;
    step(); expect_all("boot_e1", 1, 0, 0, 0, 0);
    step(); expect_all("boot_ack", 1, 1, 0, 0, 0);
    for (int i = 3; i <= 6; i++) begin
      step(); expect_all("boot_idle", 1, 1, 0, 0, 0);
    end
    step(); expect_all("boot_gate", 0, 0, 1, 1, 1);
    repeat (3) begin
      step(); expect_all("gated_hold", 0, 0, 1, 1, 1);
    end

    // Held wake request: clk_en at +1, ack at +3, no regate while held.
    wake_req = 1'b1;
    step(); expect_all("wake_en", 1, 0, 0, 1, 1);
    step(); expect_all("wake_lat", 1, 0, 0, 1, 1);
    step(); expect_all("wake_ack", 1, 1, 0, 1, 1);
    repeat (10) begin
      step(); expect_all("wake_held", 1, 1, 0, 1, 1);
    end
    wake_req = 1'b0;
    repeat (4) begin
      step(); expect_all("drop_idle", 1, 1, 0, 1, 1);
    end
    step(); expect_all("regate", 0, 0, 1, 2, 2);

    // One-cycle wake pulse dropped in WAKE still completes; then busy at idle_cnt=3.
    wake_req = 1'b1;
    step(); expect_all("pulse_wake", 1, 0, 0, 2, 2);
    wake_req = 1'b0;
    step(); expect_all("pulse_lat", 1, 0, 0, 2, 2);
    step(); expect_all("pulse_ack", 1, 1, 0, 2, 2);
    repeat (3) begin
      step(); expect_all("idle_to3", 1, 1, 0, 2, 2);
    end
    busy = 1'b1;
    step(); expect_all("busy_run", 1, 1, 0, 2, 2);
    busy = 1'b0;
    repeat (4) begin
      step(); expect_all("busy_delay", 1, 1, 0, 2, 2);
    end
    step(); expect_all("busy_gate", 0, 0, 1, 3, 3);

    // Zero threshold wakes and keeps the clock on.
    idle_thresh = 8'd0;
    step(); expect_all("thr0_wake", 1, 0, 0, 3, 3);
    step(); expect_all("thr0_lat", 1, 0, 0, 3, 3);
    step(); expect_all("thr0_ack", 1, 1, 0, 3, 3);
    repeat (30) begin
      step(); expect_all("thr0_on", 1, 1, 0, 3, 3);
    end

    // force_on and scan_mode each keep the clock on.
    idle_thresh = 8'd4;
    force_on    = 1'b1;
    repeat (30) begin
      step(); expect_all("force_on", 1, 1, 0, 3, 3);
    end
    force_on  = 1'b0;
    scan_mode = 1'b1;
    repeat (40) begin
      step(); expect_all("scan_on", 1, 1, 0, 3, 3);
    end

    // gate_te follows scan_mode without waiting for a clock edge.
    scan_mode = 1'b0;
    #1 check("gate_te_comb0", 32'(gate_te), 32'd0);
    scan_mode = 1'b1;
    #1 check("gate_te_comb1", 32'(gate_te), 32'd1);
    scan_mode = 1'b0;

    // Lowering the threshold mid-count gates on the next edge; 2-bit counter saturates.
    step(); expect_all("lower_i1", 1, 1, 0, 3, 3);
    step(); expect_all("lower_i2", 1, 1, 0, 3, 3);
    step(); expect_all("lower_i3", 1, 1, 0, 3, 3);
    idle_thresh = 8'd1;
    step(); expect_all("lower_gate", 0, 0, 1, 4, 3);
    idle_thresh = 8'd4;
    step(); expect_all("gated_pre_rst", 0, 0, 1, 4, 3);

    // Asynchronous reset while gated, then normal restart.
    rst_b = 1'b0;
    #1 expect_all("async_rst", 1, 0, 0, 0, 0);
    #3 rst_b = 1'b1;
    step(); expect_all("rst_e1", 1, 0, 0, 0, 0);
    step(); expect_all("rst_ack", 1, 1, 0, 0, 0);
    repeat (4) begin
      step(); expect_all("rst_idle", 1, 1, 0, 0, 0);
    end
    step(); expect_all("rst_gate", 0, 0, 1, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
